// File: rtl/baccarat_hand_engine.sv
// baccarat_hand_engine
//   Punto banco hand sequencer. Each step pulse captures the dealer's
//   current rank into the next hand slot (P1, B1, P2, B2). The engine then
//   applies the natural check, the player third-card rule and the banker
//   third-card table, scores the hand and latches the winner flags.
//
//   Ports
//     clock       system clock
//     resetb      asynchronous active-low reset
//     step        single-cycle deal/advance request
//     new_card    rank from dealer, 1..13 (other codes score as 0)
//     pcard1..3   player card ranks, 0 = empty slot
//     dcard1..3   banker card ranks, 0 = empty slot
//     pscore      player score 0..9 (combinational from the card slots)
//     dscore      banker score 0..9 (combinational from the card slots)
//     player_win  registered, player total >= banker total
//     dealer_win  registered, banker total >= player total
//     done        registered, round complete
//
//   Handshake: step is a plain strobe with no back-pressure. It is acted on
//   only in the deal states and in DONE; in CHK_NAT, CHK_D3 and SCORE it is
//   dropped, not queued.
module baccarat_hand_engine (
   input  logic       clock,
   input  logic       resetb,
   input  logic       step,
   input  logic [3:0] new_card,
   output logic [3:0] pcard1,
   output logic [3:0] pcard2,
   output logic [3:0] pcard3,
   output logic [3:0] dcard1,
   output logic [3:0] dcard2,
   output logic [3:0] dcard3,
   output logic [3:0] pscore,
   output logic [3:0] dscore,
   output logic       player_win,
   output logic       dealer_win,
   output logic       done
);

   typedef enum logic [3:0] {
      DEAL_P1 = 4'd0,
      DEAL_D1 = 4'd1,
      DEAL_P2 = 4'd2,
      DEAL_D2 = 4'd3,
      CHK_NAT = 4'd4,
      DEAL_P3 = 4'd5,
      CHK_D3  = 4'd6,
      DEAL_D3 = 4'd7,
      SCORE   = 4'd8,
      DONE    = 4'd9
   } state_t;

   // Current state is kept as a named signal so checkers can bind to it.
   state_t state, state_nxt;

   logic [3:0] pcard1_nxt, pcard2_nxt, pcard3_nxt;
   logic [3:0] dcard1_nxt, dcard2_nxt, dcard3_nxt;
   logic       player_win_nxt, dealer_win_nxt, done_nxt;

   // Face value: ranks 1..9 count as themselves, everything else is 0.
   function automatic logic [4:0] card_val(input logic [3:0] rank);
      return (rank >= 4'd1 && rank <= 4'd9) ? {1'b0, rank} : 5'd0;
   endfunction

   // Sum of three values is at most 27, so two subtraction steps suffice.
   function automatic logic [3:0] mod10(input logic [4:0] s);
      logic [4:0] r;
      if (s >= 5'd20)      r = s - 5'd20;
      else if (s >= 5'd10) r = s - 5'd10;
      else                 r = s;
      return r[3:0];
   endfunction

   // Banker third-card table, given the banker score and the player's
   // third card value.
   function automatic logic banker_draws(input logic [3:0] bs, input logic [4:0] p3v);
      logic d;
      case (bs)
         4'd0, 4'd1, 4'd2: d = 1'b1;
         4'd3:             d = (p3v != 5'd8);
         4'd4:             d = (p3v >= 5'd2) && (p3v <= 5'd7);
         4'd5:             d = (p3v >= 5'd4) && (p3v <= 5'd7);
         4'd6:             d = (p3v >= 5'd6) && (p3v <= 5'd7);
         default:          d = 1'b0;
      endcase
      return d;
   endfunction

   assign pscore = mod10(card_val(pcard1) + card_val(pcard2) + card_val(pcard3));
   assign dscore = mod10(card_val(dcard1) + card_val(dcard2) + card_val(dcard3));

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state      <= DEAL_P1;
         pcard1     <= 4'd0;
         pcard2     <= 4'd0;
         pcard3     <= 4'd0;
         dcard1     <= 4'd0;
         dcard2     <= 4'd0;
         dcard3     <= 4'd0;
         player_win <= 1'b0;
         dealer_win <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         pcard1     <= pcard1_nxt;
         pcard2     <= pcard2_nxt;
         pcard3     <= pcard3_nxt;
         dcard1     <= dcard1_nxt;
         dcard2     <= dcard2_nxt;
         dcard3     <= dcard3_nxt;
         player_win <= player_win_nxt;
         dealer_win <= dealer_win_nxt;
         done       <= done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      pcard1_nxt     = pcard1;
      pcard2_nxt     = pcard2;
      pcard3_nxt     = pcard3;
      dcard1_nxt     = dcard1;
      dcard2_nxt     = dcard2;
      dcard3_nxt     = dcard3;
      player_win_nxt = player_win;
      dealer_win_nxt = dealer_win;
      done_nxt       = done;

      case (state)
         DEAL_P1: if (step) begin pcard1_nxt = new_card; state_nxt = DEAL_D1; end
         DEAL_D1: if (step) begin dcard1_nxt = new_card; state_nxt = DEAL_P2; end
         DEAL_P2: if (step) begin pcard2_nxt = new_card; state_nxt = DEAL_D2; end
         DEAL_D2: if (step) begin dcard2_nxt = new_card; state_nxt = CHK_NAT; end
         CHK_NAT: begin
            if (pscore >= 4'd8 || dscore >= 4'd8) state_nxt = SCORE;
            else if (pscore <= 4'd5)              state_nxt = DEAL_P3;
            else if (dscore <= 4'd5)              state_nxt = DEAL_D3;
            else                                  state_nxt = SCORE;
         end
         DEAL_P3: if (step) begin pcard3_nxt = new_card; state_nxt = CHK_D3; end
         CHK_D3: begin
            if (banker_draws(dscore, card_val(pcard3))) state_nxt = DEAL_D3;
            else                                        state_nxt = SCORE;
         end
         DEAL_D3: if (step) begin dcard3_nxt = new_card; state_nxt = SCORE; end
         SCORE: begin
            player_win_nxt = (pscore >= dscore);
            dealer_win_nxt = (dscore >= pscore);
            done_nxt       = 1'b1;
            state_nxt      = DONE;
         end
         DONE: begin
            // The clearing step starts a fresh round but does not deal.
            if (step) begin
               pcard1_nxt     = 4'd0;
               pcard2_nxt     = 4'd0;
               pcard3_nxt     = 4'd0;
               dcard1_nxt     = 4'd0;
               dcard2_nxt     = 4'd0;
               dcard3_nxt     = 4'd0;
               player_win_nxt = 1'b0;
               dealer_win_nxt = 1'b0;
               done_nxt       = 1'b0;
               state_nxt      = DEAL_P1;
            end
         end
         default: begin
            pcard1_nxt     = 4'd0;
            pcard2_nxt     = 4'd0;
            pcard3_nxt     = 4'd0;
            dcard1_nxt     = 4'd0;
            dcard2_nxt     = 4'd0;
            dcard3_nxt     = 4'd0;
            player_win_nxt = 1'b0;
            dealer_win_nxt = 1'b0;
            done_nxt       = 1'b0;
            state_nxt      = DEAL_P1;
         end
      endcase
   end

endmodule
